// File: rtl/load_store_unit.sv
// Load/store unit: sequences a single data-memory access per request, with RMW for sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  dm_read,
   output logic                  dm_write,
   output logic [DM_ADDRESS-1:0] dm_addr,
   output logic [DATA_W-1:0]     dm_wd,
   input  logic [DATA_W-1:0]     dm_rd
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   state_e                state_q, state_d;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [1:0]            off_q;
   logic [2:0]            funct3_q;
   logic                  write_q;
   logic                  err_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     rd_q;

   logic                  accept;
   logic                  bad_f3;
   logic                  misalign;
   logic                  req_err;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_W-1:0]     load_data;
   logic [DATA_W-1:0]     merged;
   logic                  unused_addr;

   // Upper address bits are dropped so the address wraps modulo memory size.
   assign unused_addr = ^req_addr[31:DM_ADDRESS+2];

   assign accept = req_valid && req_ready;

   always_comb begin
      bad_f3 = 1'b0;
      if (req_write) begin
         bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
      end else begin
         bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_err = bad_f3 || misalign;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err) begin
                  state_d = StResp;
               end else if (req_write && (req_funct3 == 3'b010)) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd:    state_d = write_q ? StWr : StResp;
         StWr:    state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         off_q    <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         wdata_q  <= '0;
         rd_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q   <= req_addr[DM_ADDRESS+1:2];
            off_q    <= req_addr[1:0];
            funct3_q <= req_funct3;
            write_q  <= req_write;
            err_q    <= req_err;
            wdata_q  <= req_wdata;
         end
         if (state_q == StRd) begin
            rd_q <= dm_rd;
         end
      end
   end

   // Halves select on addr[1] only, so addr[0] is ignored when trapping is off.
   always_comb begin
      byte_sel = rd_q[7:0];
      unique case (off_q)
         2'b00: byte_sel = rd_q[7:0];
         2'b01: byte_sel = rd_q[15:8];
         2'b10: byte_sel = rd_q[23:16];
         2'b11: byte_sel = rd_q[31:24];
         default: byte_sel = rd_q[7:0];
      endcase
      half_sel = off_q[1] ? rd_q[31:16] : rd_q[15:0];
   end

   always_comb begin
      load_data = '0;
      case (funct3_q)
         3'b000:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         3'b010:  load_data = rd_q;
         3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
         3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      merged = rd_q;
      case (funct3_q[1:0])
         2'b00: begin
            unique case (off_q)
               2'b00: merged[7:0]   = wdata_q[7:0];
               2'b01: merged[15:8]  = wdata_q[7:0];
               2'b10: merged[23:16] = wdata_q[7:0];
               2'b11: merged[31:24] = wdata_q[7:0];
               default: merged = rd_q;
            endcase
         end
         2'b01: begin
            if (off_q[1]) begin
               merged[31:16] = wdata_q[15:0];
            end else begin
               merged[15:0] = wdata_q[15:0];
            end
         end
         default: merged = wdata_q;
      endcase
   end

   assign req_ready  = (state_q == StIdle);
   assign dm_read    = (state_q == StRd);
   assign dm_write   = (state_q == StWr);
   assign dm_addr    = addr_q;
   assign dm_wd      = dm_write ? merged : '0;
   assign resp_valid = (state_q == StResp);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : '0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, giving the data-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, giving the data width; all byte-lane rules below assume 32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  pipeline presents a memory request.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 giving size and signedness.
REQ-009 req_addr  input  32  byte address from the ALU.
REQ-010 req_wdata  input  DATA_W  store data from rs2.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  DATA_W  extended load result; 0 for stores and errors.
REQ-013 resp_err  output  1  request failed; valid only with resp_valid.
REQ-014 dm_read  output  1  drives data-memory MemRead.
REQ-015 dm_write  output  1  drives data-memory MemWrite.
REQ-016 dm_addr  output  DM_ADDRESS  word index, equal to captured req_addr[DM_ADDRESS+1:2].
REQ-017 dm_wd  output  DATA_W  full-word write data to memory.
REQ-018 dm_rd  input  DATA_W  word read data from memory, combinational while dm_read=1.

Function
REQ-019 SHALL implement the FSM states IDLE, RD, WR and RESP.
REQ-020 SHALL assert req_ready only in IDLE and SHALL capture addr, funct3, write and wdata on req_valid&&req_ready.
REQ-021 Load path SHALL be IDLE->RD->RESP: dm_read=1 in RD, dm_rd registered at the end of RD, and resp_valid in the following cycle (2 cycles after accept).
REQ-022 SW path SHALL be IDLE->WR->RESP: dm_write=1 and dm_wd=wdata in WR.
REQ-023 SB/SH path SHALL be a read-modify-write IDLE->RD->WR->RESP: the word read in RD is merged with the new lane(s) and written in WR, leaving the other bytes unchanged.
REQ-024 Lane select: a byte uses addr[1:0] (lane 0 = bits 7:0); a half uses addr[1] (0 = bits 15:0).
REQ-025 Load results: LB(000) and LH(001) sign-extend, LW(010) passes the word, LBU(100) and LHU(101) zero-extend.
REQ-026 Stores SHALL support funct3 000/001/010 only.
REQ-027 An unsupported funct3 SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, and no dm_read or dm_write.
REQ-028 RESP SHALL last exactly one cycle and then return to IDLE; there is no backpressure on the response.
REQ-029 dm_read and dm_write SHALL never be asserted in the same cycle, and both SHALL be 0 outside RD and WR.
REQ-030 dm_addr SHALL hold constant from accept until RESP.
REQ-031 Address bits above DM_ADDRESS+1 SHALL be ignored, so the address wraps modulo the memory size.

Reset
REQ-032 rst_n low SHALL immediately force IDLE with req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dm_read=0, dm_write=0, dm_addr=0 and dm_wd=0.
REQ-033 Reset mid-transaction SHALL abandon the request; an RMW aborted in RD SHALL issue no write.
REQ-034 After rst_n rises, the first rising edge SHALL be able to accept a request.

Configuration
REQ-035 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->RESP with resp_err=1 and no memory access.
REQ-036 Without LSU_MISALIGN_TRAP_EN, the unit SHALL ignore addr[0] for halves and addr[1:0] for words, access the aligned lane(s), and never raise resp_err for alignment.

Verification
REQ-037 Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> dm_write in WR with dm_addr=4; LW resp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-038 Word 0x11223344 at 0x20, then SB addr 0x22 data 0xAA, then LW 0x20 -> 0x11AA3344; the SB must show dm_read then dm_write on consecutive cycles.
REQ-039 Word 0x0000F080 at 0x30: LB 0x30 -> 0xFFFFFF80, LBU 0x30 -> 0x00000080, LH 0x30 -> 0xFFFFF080, LHU 0x30 -> 0x0000F080.
REQ-040 LW addr 0x41 -> with LSU_MISALIGN_TRAP_EN: resp_err=1, rdata=0, no dm_read; without: returns the word at 0x40 with resp_err=0.
REQ-041 funct3=011 load -> resp_err=1 one cycle after accept; rst_n low during the RD of an SH -> memory word unchanged and req_ready=1 immediately.
REQ-042 req_valid held high continuously -> accepts occur only in IDLE and never overlap, with one resp_valid per accept.
